// File: rtl/lfsr_sequence_generator.sv
// Parametrised Fibonacci LFSR with seed load, period tracking and zero-seed protection.
// Optional build macro LFSR_LOCKUP_RECOVER_EN: recover from the all-zero state.
module lfsr_sequence_generator #(
    parameter int unsigned      WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'hC),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(4'h8)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic             seq,
    output logic [WIDTH-1:0] state,
    output logic             period_done,
    output logic [WIDTH-1:0] period_len,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $fatal(1, "lfsr_sequence_generator: WIDTH must be 2..32");
        end
        if (SEED == '0) begin : g_bad_seed
            $fatal(1, "lfsr_sequence_generator: SEED must be non-zero");
        end
    endgenerate

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] load_val;
    logic             cnt_sat;
    logic             seed_zero;

    assign next_state = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
    assign seed_zero  = (seed_in == '0);
    assign load_val   = seed_zero ? SEED : seed_in;
    // A saturated counter means the seed was never revisited within range.
    assign cnt_sat    = &cnt_q;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (load) begin
            state_d = load_val;
            seed_d  = load_val;
            cnt_d   = '0;
            err_d   = seed_zero;
        end
`ifdef LFSR_LOCKUP_RECOVER_EN
        else if (state_q == '0) begin
            state_d = seed_q;
            cnt_d   = '0;
            err_d   = 1'b1;
        end
`endif
        else if (en) begin
            state_d = next_state;
            if (!cnt_sat) begin
                if (next_state == seed_q) begin
                    done_d = 1'b1;
                    len_d  = cnt_q + ONE;
                    cnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEED;
            seed_q  <= SEED;
            cnt_q   <= '0;
            len_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign seq         = state_q[WIDTH-1];
    assign state       = state_q;
    assign period_done = done_q;
    assign period_len  = len_q;
    assign load_err    = err_q;

endmodule

// File: tb/tb_lfsr_sequence_generator.sv
// Directed bench for lfsr_sequence_generator: default maximal taps plus a
// non-maximal TAPS=3 instance that exercises the all-zero lockup path.
module tb_lfsr_sequence_generator;

    logic       clk = 1'b0;
    logic       reset;
    logic       en, load;
    logic [3:0] seed_in;
    logic       seq;
    logic [3:0] state;
    logic       period_done;
    logic [3:0] period_len;
    logic       load_err;

    logic       en3, load3;
    logic [3:0] seed3;
    logic       seq3;
    logic [3:0] state3;
    logic       done3;
    logic [3:0] len3;
    logic       err3;

    int n_cmp = 0;
    int n_err = 0;

    logic [3:0] exp_seq [15] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD,
                                 4'hA, 4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
    logic [3:0] exp_from3 [15] = '{4'h6, 4'hD, 4'hA, 4'h5, 4'hB, 4'h7, 4'hF,
                                   4'hE, 4'hC, 4'h8, 4'h1, 4'h2, 4'h4, 4'h9, 4'h3};

    lfsr_sequence_generator u_dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load       (load),
        .seed_in    (seed_in),
        .seq        (seq),
        .state      (state),
        .period_done(period_done),
        .period_len (period_len),
        .load_err   (load_err)
    );

    lfsr_sequence_generator #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h8)) u_dut3 (
        .clk        (clk),
        .reset      (reset),
        .en         (en3),
        .load       (load3),
        .seed_in    (seed3),
        .seq        (seq3),
        .state      (state3),
        .period_done(done3),
        .period_len (len3),
        .load_err   (err3)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b0; load = 1'b0; seed_in = 4'h0;
        en3 = 1'b0; load3 = 1'b0; seed3 = 4'h0;
        tick();
        tick();
        n_cmp++;
        if (state !== 4'h8) begin
            n_err++; $display("FAIL reset_state: got %h want 8", state);
        end
        n_cmp++;
        if (seq !== 1'b1) begin
            n_err++; $display("FAIL reset_seq: got %b want 1", seq);
        end
        n_cmp++;
        if ({period_done, load_err, period_len} !== 6'b0) begin
            n_err++; $display("FAIL reset_flags: done=%b err=%b len=%h want 0",
                              period_done, load_err, period_len);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequence();
        en = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++;
            if (state !== exp_seq[i] || seq !== exp_seq[i][3]) begin
                n_err++;
                $display("FAIL seq_step%0d: got state=%h seq=%b want %h", i, state, seq, exp_seq[i]);
            end
            n_cmp++;
            if (period_done !== (i == 14)) begin
                n_err++; $display("FAIL seq_done%0d: got %b want %b", i, period_done, i == 14);
            end
        end
        n_cmp++;
        if (period_len !== 4'd15) begin
            n_err++; $display("FAIL seq_len: got %0d want 15", period_len);
        end
        en = 1'b0;
    endtask

    task automatic test_enable();
        logic [3:0] exp_st [4];
        logic       pat [4];
        exp_st = '{4'h1, 4'h1, 4'h1, 4'h2};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            en = pat[i];
            tick();
            n_cmp++;
            if (state !== exp_st[i]) begin
                n_err++; $display("FAIL en_step%0d: got %h want %h", i, state, exp_st[i]);
            end
        end
        en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tick();
            n_cmp++;
            if (period_done !== (i == 12)) begin
                n_err++; $display("FAIL en_done%0d: got %b want %b", i, period_done, i == 12);
            end
        end
        n_cmp++;
        if (state !== 4'h8 || period_len !== 4'd15) begin
            n_err++; $display("FAIL en_period: got state=%h len=%0d want 8/15", state, period_len);
        end
        en = 1'b0;
    endtask

    task automatic test_load();
        load = 1'b1; seed_in = 4'h3; en = 1'b1;
        tick();
        load = 1'b0;
        n_cmp++;
        if (state !== 4'h3 || period_done !== 1'b0 || load_err !== 1'b0) begin
            n_err++; $display("FAIL load_seed: got state=%h done=%b err=%b want 3/0/0",
                              state, period_done, load_err);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++;
            if (state !== exp_from3[i] || period_done !== (i == 14)) begin
                n_err++;
                $display("FAIL load_step%0d: got state=%h done=%b want %h/%b",
                         i, state, period_done, exp_from3[i], i == 14);
            end
        end
        n_cmp++;
        if (period_len !== 4'd15) begin
            n_err++; $display("FAIL load_len: got %0d want 15", period_len);
        end
        en = 1'b0;
    endtask

    task automatic test_zero_load();
        load = 1'b1; seed_in = 4'h0;
        tick();
        load = 1'b0;
        n_cmp++;
        if (state !== 4'h8 || load_err !== 1'b1 || period_done !== 1'b0) begin
            n_err++; $display("FAIL zload: got state=%h err=%b done=%b want 8/1/0",
                              state, load_err, period_done);
        end
        tick();
        n_cmp++;
        if (state !== 4'h8 || load_err !== 1'b0 || period_done !== 1'b0) begin
            n_err++; $display("FAIL zload_after: got state=%h err=%b done=%b want 8/0/0",
                              state, load_err, period_done);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        en = 1'b0;
        n_cmp++;
        if (state !== 4'hB) begin
            n_err++; $display("FAIL areset_pre: got %h want B", state);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (state !== 4'h8 || seq !== 1'b1 || period_len !== 4'd0 ||
            period_done !== 1'b0 || load_err !== 1'b0) begin
            n_err++;
            $display("FAIL areset: got state=%h seq=%b len=%0d done=%b err=%b want 8/1/0/0/0",
                     state, seq, period_len, period_done, load_err);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_lockup();
        load3 = 1'b1; seed3 = 4'h8;
        tick();
        load3 = 1'b0; en3 = 1'b1;
        n_cmp++;
        if (state3 !== 4'h8 || err3 !== 1'b0) begin
            n_err++; $display("FAIL lock_load: got state=%h err=%b want 8/0", state3, err3);
        end
        tick();
        n_cmp++;
        if (state3 !== 4'h0) begin
            n_err++; $display("FAIL lock_zero: got %h want 0", state3);
        end
        tick();
`ifdef LFSR_LOCKUP_RECOVER_EN
        n_cmp++;
        if (state3 !== 4'h8 || err3 !== 1'b1 || done3 !== 1'b0) begin
            n_err++; $display("FAIL lock_recover: got state=%h err=%b done=%b want 8/1/0",
                              state3, err3, done3);
        end
        tick();
        n_cmp++;
        if (state3 !== 4'h0 || err3 !== 1'b0) begin
            n_err++; $display("FAIL lock_again: got state=%h err=%b want 0/0", state3, err3);
        end
`else
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (state3 !== 4'h0 || err3 !== 1'b0 || done3 !== 1'b0) begin
                n_err++; $display("FAIL lock_stuck%0d: got state=%h err=%b done=%b want 0/0/0",
                                  i, state3, err3, done3);
            end
            tick();
        end
`endif
        en3 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_enable();
        test_load();
        test_zero_load();
        test_async_reset();
        test_lockup();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
